// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Purpose : Shared definitions for the data memory responder: the FSM state
//           encoding, default geometry/timing parameters and the address error
//           rule (alignment and range) used by the responder.
// Contents: state_t, DEFAULT_DEPTH, DEFAULT_WAIT_CYCLES, WAIT_CNT_W,
//           ALIGN_BITS, ALIGN_MASK, addr_err().
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  // Wide enough for the largest wait-state count (15).
  localparam int WAIT_CNT_W = 4;

  // Word accesses only: the two byte-offset bits must be zero.
  localparam int          ALIGN_BITS = 2;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  // An access errors when it is misaligned or when any address bit above the
  // word-index field is set (the field spans idx_w bits starting at bit 2).
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned idx_w);
    logic [31:0] upper_mask;
    upper_mask = ~((32'd1 << (idx_w + ALIGN_BITS)) - 32'd1);
    return (|(addr & ALIGN_MASK)) || (|(addr & upper_mask));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Purpose : Request/response handshake bundle between an initiator and the
//           data memory responder.
// Signals : req_valid, req_write, req_addr, req_wdata (initiator -> responder)
//           req_ready                                  (responder -> initiator)
//           rsp_valid, rsp_rdata, rsp_err              (responder -> initiator)
//           rsp_ready                                  (initiator -> responder)
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Purpose : DEPTH x 32-bit word storage. Asynchronous clear of every word on
//           reset, synchronous single-port write, combinational read. Word 0 is
//           also exposed directly for display purposes.
// Ports   : clk_in   - clock
//           rst_in   - asynchronous active-low clear
//           we       - write enable
//           waddr    - write word index
//           wdata    - write data
//           raddr    - read word index
//           rdata    - combinational read data
//           word0    - current contents of word 0
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  output logic [31:0]      word0
);

  logic [31:0] mem_reg [DEPTH];

  // Clear-on-reset rules out block RAM; the array lives in fabric registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];
  assign word0 = mem_reg[0];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Purpose : Single-outstanding-request word memory responder. A request is
//           accepted in IDLE, held for WAIT_CYCLES wait states, then the memory
//           access (write commit or read sample) happens on the edge that
//           enters RESP. The response is held until the initiator consumes it.
// Params  : DEPTH       - number of 32-bit words (power of two, 4..1024)
//           WAIT_CYCLES - wait states between acceptance and access (0..15)
// Ports   : clk_in      - clock, rising edge
//           rst_in      - asynchronous active-low reset
//           bus         - request/response handshake (slave side)
//           test_value  - bits [15:0] of word 0, for board display
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  data_mem_responder_if.slave   bus,
  output logic [15:0]           test_value
);

  localparam int IDX_W = $clog2(DEPTH);

  // Counter preload; WAIT_CYCLES = 0 never enters WAIT, so its value is moot.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                  state_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
  logic                    cap_write_reg;
  logic [31:0]             cap_addr_reg;
  logic [31:0]             cap_wdata_reg;
  logic                    rsp_valid_reg;
  logic [31:0]             rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic                    accept;
  logic                    enter_resp;
  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic                    acc_err;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [31:0]             mem_rdata;
  logic [31:0]             mem_word0;

  // -------------------------------------------------------------------------
  // Access path. With zero wait states the access happens on the acceptance
  // edge itself, before the capture registers hold the request, so in IDLE the
  // live bus inputs feed the access; otherwise the captured request does.
  // -------------------------------------------------------------------------
  always_comb begin
    accept     = bus.req_valid && bus.req_ready;
    acc_write  = cap_write_reg;
    acc_addr   = cap_addr_reg;
    acc_wdata  = cap_wdata_reg;
    if (state_reg == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
    enter_resp = ((state_reg == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                 ((state_reg == ST_WAIT) && (wait_cnt_reg == '0));
    acc_err    = addr_err(acc_addr, IDX_W);
    mem_we     = enter_resp && acc_write && !acc_err;
    mem_idx    = acc_addr[IDX_W+1:2];
  end

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we     (mem_we),
    .waddr  (mem_idx),
    .wdata  (acc_wdata),
    .raddr  (mem_idx),
    .rdata  (mem_rdata),
    .word0  (mem_word0)
  );

  // -------------------------------------------------------------------------
  // Control FSM with registered response outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      cap_write_reg <= 1'b0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cap_write_reg <= bus.req_write;
            cap_addr_reg  <= bus.req_addr;
            cap_wdata_reg <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_reg <= ST_RESP;
            end else begin
              wait_cnt_reg <= WAIT_LOAD;
              state_reg    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      // Response is latched on the same edge the access takes place.
      if (enter_resp) begin
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= acc_err;
        rsp_rdata_reg <= (acc_write || acc_err) ? 32'd0 : mem_rdata;
      end
    end
  end

  // Gating with rst_in keeps req_ready low while reset is held.
  assign bus.req_ready = (state_reg == ST_IDLE) && rst_in;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign test_value    = mem_word0[15:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. Two instances share clock and reset:
// one with default parameters (WAIT_CYCLES = 2, DEPTH = 64) and one built with
// WAIT_CYCLES = 0. The sel signal routes stimulus and observation to one of
// them at a time.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk;
  logic rst_n;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  logic [15:0] tv2;
  logic [15:0] tv0;

  logic        sel;            // 0: default instance, 1: zero-wait instance
  logic        drv_valid;
  logic        drv_write;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;
  logic        drv_rsp_ready;

  int checks;
  int failures;

  assign bus2.req_valid = drv_valid && !sel;
  assign bus0.req_valid = drv_valid && sel;
  assign bus2.req_write = drv_write;
  assign bus0.req_write = drv_write;
  assign bus2.req_addr  = drv_addr;
  assign bus0.req_addr  = drv_addr;
  assign bus2.req_wdata = drv_wdata;
  assign bus0.req_wdata = drv_wdata;
  assign bus2.rsp_ready = drv_rsp_ready;
  assign bus0.rsp_ready = drv_rsp_ready;

  wire        obs_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  wire        obs_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  wire [31:0] obs_rdata     = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  wire        obs_err       = sel ? bus0.rsp_err   : bus2.rsp_err;
  wire [15:0] obs_tv        = sel ? tv0 : tv2;

  data_mem_responder dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .bus        (bus2),
    .test_value (tv2)
  );

  data_mem_responder #(
    .DEPTH       (64),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .bus        (bus0),
    .test_value (tv0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete request/response exchange. hold = number of cycles the
  // response is left unconsumed (0 = rsp_ready held high throughout).
  task automatic txn(input logic s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    sel           = s;
    drv_valid     = 1'b1;
    drv_write     = w;
    drv_addr      = a;
    drv_wdata     = d;
    drv_rsp_ready = (hold == 0);
    n = 0;
    while (!obs_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(obs_req_ready), 32'd1);
    // Acceptance happens on the coming rising edge; scramble inputs afterwards
    // so the captured copy is what matters.
    @(negedge clk);
    drv_valid = 1'b0;
    drv_write = ~w;
    drv_addr  = 32'hFFFF_FFFF;
    drv_wdata = 32'h0BAD_0BAD;
    lat = 1;
    while (!obs_rsp_valid && lat < 40) begin
      chk("req_ready_busy", 32'(obs_req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    rd = obs_rdata;
    er = obs_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(obs_rsp_valid), 32'd1);
      chk("hold_rdata", obs_rdata, rd);
      chk("hold_req_ready", 32'(obs_req_ready), 32'd0);
    end
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    drv_rsp_ready = 1'b0;
    chk("rsp_consumed", 32'(obs_rsp_valid), 32'd0);
    chk("ready_after_consume", 32'(obs_req_ready), 32'd1);
    $display("txn sel=%0d w=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             s, w, a, d, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    checks        = 0;
    failures      = 0;
    sel           = 1'b0;
    drv_valid     = 1'b0;
    drv_write     = 1'b0;
    drv_addr      = '0;
    drv_wdata     = '0;
    drv_rsp_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus2.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus2.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus2.rsp_err), 32'd0);
    chk("rst_test_value", 32'(tv2), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req_ready", 32'(bus2.req_ready), 32'd1);

    // Store word 0, then load it back.
    txn(1'b0, 1'b1, 32'h0000_0000, 32'h1234_ABCD, 0, rd, er, lat);
    chk("st0_lat", 32'(lat), 32'd3);
    chk("st0_err", 32'(er), 32'd0);
    chk("st0_rdata", rd, 32'd0);
    chk("st0_test_value", 32'(obs_tv), 32'h0000_ABCD);

    txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, rd, er, lat);
    chk("ld0_lat", 32'(lat), 32'd3);
    chk("ld0_rdata", rd, 32'h1234_ABCD);
    chk("ld0_err", 32'(er), 32'd0);

    // Word 1 gets a known value, then erroring stores must leave it alone.
    txn(1'b0, 1'b1, 32'h0000_0004, 32'h1111_2222, 0, rd, er, lat);
    chk("st1_err", 32'(er), 32'd0);
    txn(1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 0, rd, er, lat);
    chk("st_mis_err", 32'(er), 32'd1);
    chk("st_mis_rdata", rd, 32'd0);
    txn(1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 0, rd, er, lat);
    chk("st_oor_err", 32'(er), 32'd1);
    chk("st_oor_rdata", rd, 32'd0);
    chk("st_oor_lat", 32'(lat), 32'd3);
    txn(1'b0, 1'b0, 32'h0000_0002, 32'h0, 0, rd, er, lat);
    chk("ld_mis_err", 32'(er), 32'd1);
    chk("ld_mis_rdata", rd, 32'd0);
    txn(1'b0, 1'b0, 32'h0000_0004, 32'h0, 0, rd, er, lat);
    chk("ld1_rdata", rd, 32'h1111_2222);
    chk("ld1_err", 32'(er), 32'd0);
    txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, rd, er, lat);
    chk("ld0_again_rdata", rd, 32'h1234_ABCD);
    chk("tv_unchanged", 32'(obs_tv), 32'h0000_ABCD);

    // Last word, with the response held off for 5 cycles.
    txn(1'b0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 0, rd, er, lat);
    chk("st63_err", 32'(er), 32'd0);
    txn(1'b0, 1'b0, 32'h0000_00FC, 32'h0, 5, rd, er, lat);
    chk("ld63_lat", 32'(lat), 32'd3);
    chk("ld63_rdata", rd, 32'hCAFE_F00D);
    chk("ld63_err", 32'(er), 32'd0);

    // Reset during WAIT aborts the store and delivers no response.
    @(negedge clk);
    sel           = 1'b0;
    drv_valid     = 1'b1;
    drv_write     = 1'b1;
    drv_addr      = 32'h0000_0004;
    drv_wdata     = 32'hDEAD_BEEF;
    drv_rsp_ready = 1'b1;
    chk("abort_req_ready", 32'(obs_req_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    chk("abort_in_wait", 32'(obs_req_ready), 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(obs_rsp_valid), 32'd0);
    end
    chk("abort_tv_cleared", 32'(obs_tv), 32'd0);
    rst_n         = 1'b1;
    drv_rsp_ready = 1'b0;
    #1;
    chk("abort_no_rsp_after", 32'(obs_rsp_valid), 32'd0);
    txn(1'b0, 1'b0, 32'h0000_0004, 32'h0, 0, rd, er, lat);
    chk("abort_ld1_rdata", rd, 32'd0);
    chk("abort_ld1_err", 32'(er), 32'd0);

    // Zero-wait instance.
    txn(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0005, 0, rd, er, lat);
    chk("w0_st_lat", 32'(lat), 32'd1);
    chk("w0_st_err", 32'(er), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, rd, er, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_rdata", rd, 32'h0000_0005);
    chk("w0_ld_err", 32'(er), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and memory access (0..15).
REQ-003 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 rsp_valid  output  1  response presented.
REQ-011 rsp_rdata  output  32  load data; 0 for stores and errored accesses.
REQ-012 rsp_err  output  1  access was misaligned or out of range.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 test_value  output  16  bits [15:0] of word 0, for board display.

Function
REQ-015 FSM states IDLE, WAIT, RESP; rst_in low forces IDLE.
REQ-016 req_ready = 1 only in IDLE with rst_in high; 0 in WAIT and RESP.
REQ-017 Acceptance = req_valid & req_ready at an edge; req_write, req_addr and req_wdata are captured at that edge; inputs are ignored afterwards until the next acceptance.
REQ-018 On acceptance: if WAIT_CYCLES = 0, go to RESP; otherwise load the wait counter with WAIT_CYCLES-1 and go to WAIT.
REQ-019 WAIT: decrement the counter each cycle; at the edge where the counter is 0, go to RESP.
REQ-020 The memory access (write commit or read sample) happens on the edge that enters RESP; rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 Word index = captured_addr[log2(DEPTH)+1:2].
REQ-022 Error when captured_addr[1:0] != 0 or any address bit above log2(DEPTH)+1 is set; on error: no write, rsp_rdata = 0, rsp_err = 1.
REQ-023 Store without error writes all 32 bits; rsp_rdata = 0, rsp_err = 0.
REQ-024 Load without error returns the word at the index.
REQ-025 RESP: rsp_valid, rsp_rdata and rsp_err stay stable until an edge with rsp_ready = 1; then go to IDLE and deassert rsp_valid.
REQ-026 No back-to-back overlap: the next request can be accepted, at the earliest, in the cycle after the response is consumed.
REQ-027 test_value reflects a store to word 0 on the cycle after that store commits.
REQ-028 A load of word 0 issued after a store to word 0 returns the stored value (no stale data).

Reset
REQ-029 While rst_in = 0: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0, captured request registers 0, all memory words 0, test_value 0.
REQ-030 Reset asserted mid-transaction (WAIT or RESP) aborts the transaction: no write commits and no response is delivered.
REQ-031 The first acceptance is possible on the first rising edge after rst_in returns high.

Structure
REQ-032 A shared package holds the FSM state enum, the default DEPTH and WAIT_CYCLES, and the error rule constants.
REQ-033 One sub-module, mem_array (DEPTH x 32 storage with async clear, synchronous write, combinational read), is instantiated once; the FSM and handshake logic are in data_mem_responder.

Verification
REQ-034 Reset, then store addr 0x0 data 0x1234ABCD with rsp_ready=1 -> rsp_valid 3 cycles after acceptance, rsp_err 0, test_value 0xABCD the next cycle.
REQ-035 Load addr 0x0 after REQ-034 -> rsp_rdata 0x1234ABCD, rsp_err 0.
REQ-036 Store to addr 0x6 and store to addr 0x100 (DEPTH 64) -> rsp_err 1, rsp_rdata 0, later loads of words 1 and 0 are unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles during a load of 0xFC -> rsp_valid and rsp_rdata stable, req_ready 0 throughout; accepted only after rsp_ready rises.
REQ-038 Assert rst_in low during WAIT of a store 0xDEADBEEF to 0x4 -> no response; a load of 0x4 after reset returns 0.
REQ-039 WAIT_CYCLES=0 build: store then load of 0x8 value 0x5 -> each rsp_valid 1 cycle after acceptance, load returns 0x5.
